// File: rtl/adder_pkg.sv
// Shared types and step decode for the three-operand adder datapath.
package adder_pkg;

   typedef enum logic [2:0] {
      STEP_NONE,
      STEP_LOAD,
      STEP_ADD_Y,
      STEP_ADD_Z,
      STEP_ILLEGAL
   } step_t;

   typedef enum logic [1:0] {
      SEQ_IDLE,
      SEQ_LOADED,
      SEQ_ADDED
   } seq_t;

   // Only the three exact strobe patterns are legal; anything else with EN high is a fault.
   function automatic step_t decode_step(input logic en, input logic s0,
                                         input logic s1, input logic s2);
      step_t step;
      if (!en) begin
         step = STEP_NONE;
      end else begin
         case ({s0, s1, s2})
            3'b100:  step = STEP_LOAD;
            3'b010:  step = STEP_ADD_Y;
            3'b011:  step = STEP_ADD_Z;
            default: step = STEP_ILLEGAL;
         endcase
      end
      return step;
   endfunction

endpackage

// File: rtl/adder_result_buf.sv
// Result register with valid/ready handshake and sticky overrun flag.
module adder_result_buf #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             commit,
   input  logic [WIDTH+1:0] sum,
   input  logic             RES_READY,
   input  logic             CLR,
   output logic [WIDTH+1:0] RES,
   output logic             RES_VALID,
   output logic             OVR
);

   logic ovr_set;

   assign ovr_set = commit && RES_VALID && !RES_READY;

   // A commit always wins over a handshake so the fresh result stays valid.
   always_ff @(posedge clk) begin
      if (reset) begin
         RES       <= '0;
         RES_VALID <= 1'b0;
         OVR       <= 1'b0;
      end else begin
         if (commit) begin
            RES       <= sum;
            RES_VALID <= 1'b1;
         end else if (RES_VALID && RES_READY) begin
            RES_VALID <= 1'b0;
         end
         OVR <= ovr_set | (OVR & ~CLR);
      end
   end

endmodule

// File: rtl/adder_datapath.sv
// Three-operand adder datapath: step decode, order checker, accumulator and result port.
module adder_datapath
   import adder_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             EN,
   input  logic             S0,
   input  logic             S1,
   input  logic             S2,
   input  logic [WIDTH-1:0] X,
   input  logic [WIDTH-1:0] Y,
   input  logic [WIDTH-1:0] Z,
   output logic [WIDTH+1:0] RES,
   output logic             RES_VALID,
   input  logic             RES_READY,
   output logic             SEQ_ERR,
   output logic             OVR,
   input  logic             CLR
);

   step_t            step;
   seq_t             state;
   logic [WIDTH+1:0] acc;
   logic [WIDTH-1:0] yr;
   logic [WIDTH-1:0] zr;
   logic [WIDTH+1:0] sum;
   logic             commit;
   logic             seq_fault;

   assign step = decode_step(EN, S0, S1, S2);
   assign sum  = acc + {2'b00, zr};

   // A LOAD is always honoured, but only counts as in-order when starting from idle.
   always_comb begin
      seq_fault = 1'b0;
      commit    = 1'b0;
      case (step)
         STEP_LOAD:    seq_fault = (state != SEQ_IDLE);
         STEP_ADD_Y:   seq_fault = (state != SEQ_LOADED);
         STEP_ADD_Z: begin
            commit    = (state == SEQ_ADDED);
            seq_fault = (state != SEQ_ADDED);
         end
         STEP_ILLEGAL: seq_fault = 1'b1;
         default:      ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= SEQ_IDLE;
         acc     <= '0;
         yr      <= '0;
         zr      <= '0;
         SEQ_ERR <= 1'b0;
      end else begin
         SEQ_ERR <= seq_fault | (SEQ_ERR & ~CLR);
         case (step)
            STEP_LOAD: begin
               acc   <= {2'b00, X};
               yr    <= Y;
               zr    <= Z;
               state <= SEQ_LOADED;
            end
            STEP_ADD_Y: begin
               if (state == SEQ_LOADED) begin
                  acc   <= acc + {2'b00, yr};
                  state <= SEQ_ADDED;
               end else begin
                  state <= SEQ_IDLE;
               end
            end
            STEP_ADD_Z: begin
               if (commit) acc <= sum;
               state <= SEQ_IDLE;
            end
            STEP_ILLEGAL: state <= SEQ_IDLE;
            default:      ;
         endcase
      end
   end

   adder_result_buf #(.WIDTH(WIDTH)) u_result_buf (
      .clk       (clk),
      .reset     (reset),
      .commit    (commit),
      .sum       (sum),
      .RES_READY (RES_READY),
      .CLR       (CLR),
      .RES       (RES),
      .RES_VALID (RES_VALID),
      .OVR       (OVR)
   );

endmodule

// File: tb/tb_adder_datapath.sv
// Directed and randomized bench for adder_datapath against an operand-level reference model.
module tb_adder_datapath;
   import adder_pkg::*;

   logic       clk = 1'b0;
   logic       reset;
   logic       EN, S0, S1, S2;
   logic [7:0] X, Y, Z;
   logic [9:0] RES;
   logic       RES_VALID, RES_READY, SEQ_ERR, OVR, CLR;

   int checks = 0;
   int errors = 0;

   // Reference model: remembers the loaded operands and how far through the sequence we are.
   int   m_phase;
   int   m_x, m_y, m_z;
   int   m_res;
   logic m_valid, m_seq_err, m_ovr;

   adder_datapath #(.WIDTH(8)) dut (
      .clk       (clk),
      .reset     (reset),
      .EN        (EN),
      .S0        (S0),
      .S1        (S1),
      .S2        (S2),
      .X         (X),
      .Y         (Y),
      .Z         (Z),
      .RES       (RES),
      .RES_VALID (RES_VALID),
      .RES_READY (RES_READY),
      .SEQ_ERR   (SEQ_ERR),
      .OVR       (OVR),
      .CLR       (CLR)
   );

   always #5 clk = ~clk;

   task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic checkOutput(input string tag);
      checkValue({tag, ".RES"},       32'(RES),       32'(m_res));
      checkValue({tag, ".RES_VALID"}, 32'(RES_VALID), 32'(m_valid));
      checkValue({tag, ".SEQ_ERR"},   32'(SEQ_ERR),   32'(m_seq_err));
      checkValue({tag, ".OVR"},       32'(OVR),       32'(m_ovr));
   endtask

   task automatic applyReset();
      reset = 1'b1;
      EN = 1'b1; S0 = 1'b1; S1 = 1'b1; S2 = 1'b1; CLR = 1'b0;
      @(posedge clk); #1;
      reset = 1'b0;
      m_phase = 0; m_x = 0; m_y = 0; m_z = 0; m_res = 0;
      m_valid = 1'b0; m_seq_err = 1'b0; m_ovr = 1'b0;
   endtask

   // Drives one cycle of inputs, advances the model by the same rules, then waits past the edge.
   task automatic applyStimulus(input logic en, input logic s0, input logic s1, input logic s2,
                                input int x, input int y, input int z,
                                input logic ready, input logic clr);
      step_t st;
      logic  commit, err, ovr_set;
      EN = en; S0 = s0; S1 = s1; S2 = s2;
      X = 8'(x); Y = 8'(y); Z = 8'(z);
      RES_READY = ready; CLR = clr;
      st = decode_step(en, s0, s1, s2);
      commit = 1'b0; err = 1'b0; ovr_set = 1'b0;
      case (st)
         STEP_LOAD: begin
            err = (m_phase != 0);
            m_x = x; m_y = y; m_z = z;
            m_phase = 1;
         end
         STEP_ADD_Y: begin
            if (m_phase == 1) m_phase = 2;
            else begin err = 1'b1; m_phase = 0; end
         end
         STEP_ADD_Z: begin
            if (m_phase == 2) commit = 1'b1;
            else err = 1'b1;
            m_phase = 0;
         end
         STEP_ILLEGAL: begin err = 1'b1; m_phase = 0; end
         default: ;
      endcase
      if (commit) begin
         ovr_set = m_valid && !ready;
         m_res   = m_x + m_y + m_z;
         m_valid = 1'b1;
      end else if (m_valid && ready) begin
         m_valid = 1'b0;
      end
      m_ovr     = ovr_set | (m_ovr & !clr);
      m_seq_err = err | (m_seq_err & !clr);
      @(posedge clk); #1;
   endtask

   task automatic runSequence(input int x, input int y, input int z, input logic ready);
      applyStimulus(1, 1, 0, 0, x, y, z, ready, 0);
      applyStimulus(1, 0, 1, 0, 0, 0, 0, ready, 0);
      applyStimulus(1, 0, 1, 1, 0, 0, 0, ready, 0);
   endtask

   initial begin
      RES_READY = 1'b0; X = '0; Y = '0; Z = '0;
      applyReset();
      checkOutput("reset");

      // Basic sum with consumer ready
      runSequence(10, 20, 30, 1);
      checkOutput("sum60");
      checkValue("sum60.const", 32'(RES), 60);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0);
      checkOutput("sum60.consumed");
      checkValue("sum60.valid_drop", 32'(RES_VALID), 0);

      // Maximum operands with EN gaps; X changes after LOAD must be ignored
      applyStimulus(1, 1, 0, 0, 255, 255, 255, 0, 0);
      applyStimulus(0, 0, 0, 0, 1, 1, 1, 0, 0);
      applyStimulus(1, 0, 1, 0, 3, 3, 3, 0, 0);
      applyStimulus(0, 0, 0, 0, 5, 5, 5, 0, 0);
      checkValue("max.not_yet_valid", 32'(RES_VALID), 0);
      applyStimulus(1, 0, 1, 1, 7, 7, 7, 0, 0);
      checkOutput("max");
      checkValue("max.const", 32'(RES), 765);

      // Back-to-back with consumer stalled: overrun, then CLR keeps RES
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 1);
      runSequence(1, 2, 3, 0);
      runSequence(4, 5, 6, 0);
      checkOutput("overrun");
      checkValue("overrun.ovr", 32'(OVR), 1);
      checkValue("overrun.res", 32'(RES), 15);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1);
      checkOutput("overrun.clr");
      checkValue("overrun.clr_ovr", 32'(OVR), 0);

      // Out-of-order ADD_Y and an illegal strobe pattern
      applyStimulus(1, 0, 1, 0, 0, 0, 0, 1, 0);
      checkOutput("addy_idle");
      checkValue("addy_idle.seq_err", 32'(SEQ_ERR), 1);
      applyStimulus(1, 1, 0, 1, 0, 0, 0, 1, 0);
      checkOutput("illegal");
      runSequence(11, 22, 33, 1);
      checkOutput("after_err");
      checkValue("after_err.const", 32'(RES), 66);

      // Reset during ADDED
      applyStimulus(1, 1, 0, 0, 50, 60, 70, 1, 0);
      applyStimulus(1, 0, 1, 0, 0, 0, 0, 1, 0);
      applyReset();
      checkOutput("mid_reset");
      runSequence(7, 8, 9, 1);
      checkOutput("post_reset");
      checkValue("post_reset.const", 32'(RES), 24);
      checkValue("post_reset.seq_err", 32'(SEQ_ERR), 0);

      // Restarting LOAD
      applyStimulus(1, 1, 0, 0, 1, 100, 100, 1, 0);
      runSequence(2, 3, 4, 1);
      checkOutput("reload");
      checkValue("reload.const", 32'(RES), 9);
      checkValue("reload.seq_err", 32'(SEQ_ERR), 1);

      // Randomized traffic, mostly legal sequences with occasional faults
      for (int i = 0; i < 400; i++) begin
         int   r;
         logic rdy, clr;
         r   = int'($urandom_range(0, 9));
         rdy = 1'($urandom_range(0, 1));
         clr = ($urandom_range(0, 15) == 0);
         if (r < 7) begin
            case (m_phase)
               0: applyStimulus(1, 1, 0, 0, int'($urandom_range(0, 255)),
                                int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), rdy, clr);
               1: applyStimulus(1, 0, 1, 0, int'($urandom_range(0, 255)), 0, 0, rdy, clr);
               default: applyStimulus(1, 0, 1, 1, 0, 0, 0, rdy, clr);
            endcase
         end else if (r == 7) begin
            applyStimulus(0, 1'($urandom), 1'($urandom), 1'($urandom), 0, 0, 0, rdy, clr);
         end else if (r == 8) begin
            applyStimulus(1, 1, 0, 0, int'($urandom_range(0, 255)),
                          int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), rdy, clr);
         end else begin
            applyStimulus(1, 1'($urandom), 1'($urandom), 1'($urandom),
                          int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                          int'($urandom_range(0, 255)), rdy, clr);
         end
         checkOutput($sformatf("rand%0d", i));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/adder_datapath.md
# adder_datapath

Datapath for the pipelined three-operand adder. It sits on the receiving end of the sequencer's EN/S0/S1/S2 control bus. Under those strobes it snapshots operands X, Y and Z, accumulates X+Y+Z over three enabled cycles, and presents the sum through a valid/ready result port. It also checks that the control strobes arrive in the legal order and flags sequencing faults and result overruns.

## Interface
- WIDTH, 8, operand width in bits; result width is WIDTH+2.
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high; one clock; all state cleared on the clk edge while high.
- EN  in  1  step enable from the sequencer.
- S0  in  1  load strobe.
- S1  in  1  add strobe.
- S2  in  1  final-add / commit strobe.
- X, Y, Z  in  WIDTH each  unsigned operands, sampled only on a load step.
- RES  out  WIDTH+2  unsigned sum X+Y+Z; reset 0.
- RES_VALID  out  1  RES holds an unconsumed result; reset 0.
- RES_READY  in  1  consumer accepts RES when RES_VALID && RES_READY.
- SEQ_ERR  out  1  sticky illegal/out-of-order strobe flag; reset 0.
- OVR  out  1  sticky result-overrun flag; reset 0.
- CLR  in  1  synchronous clear of SEQ_ERR and OVR only.

## Operation
Step decode happens when EN=1; EN=0 means idle and all registers hold.
- LOAD: S0=1, S1=0, S2=0. Actions: ACC <= zero-extended X; YR <= Y; ZR <= Z.
- ADD_Y: S1=1, S0=0, S2=0. Action: ACC <= ACC + YR.
- ADD_Z: S1=1, S2=1, S0=0. Actions: ACC <= ACC + ZR; RES <= ACC + ZR; RES_VALID <= 1.
- Any other combination with EN=1 is ILLEGAL. SEQ_ERR <= 1; ACC, YR, ZR and RES are unchanged.

Order checker FSM, states IDLE, LOADED, ADDED:
- IDLE: LOAD goes to LOADED.
- LOADED: ADD_Y goes to ADDED.
- ADDED: ADD_Z goes to IDLE and commits.
- LOAD in any state restarts the sequence: its actions execute and the FSM goes to LOADED. If the FSM was not IDLE, SEQ_ERR <= 1.
- ADD_Y or ADD_Z out of order: SEQ_ERR <= 1, no register update, FSM goes to IDLE.
- ILLEGAL: FSM goes to IDLE.
- EN=0: FSM holds.

Arithmetic:
- Unsigned; the accumulator is WIDTH+2 bits and never overflows, since the maximum is 3*(2^WIDTH-1).
- No truncation anywhere.

Result port:
- A handshake (RES_VALID && RES_READY) clears RES_VALID unless a commit happens in the same cycle.
- Commit with RES_VALID=1 and RES_READY=0: RES is overwritten, RES_VALID stays 1, OVR <= 1.
- Commit with RES_VALID=1 and RES_READY=1: the old result is consumed, the new RES is valid, and OVR is unchanged.
- CLR and a new error in the same cycle: the error wins and the flag ends set.

Reset:
- Asserting reset mid-sequence returns the FSM to IDLE.
- ACC, YR, ZR, RES, RES_VALID, SEQ_ERR and OVR are all cleared to 0.
- reset overrides every other input.

## Timing
- All updates occur on the rising clk edge at the end of the cycle in which the strobes are high.
- The normal sequence is LOAD, ADD_Y, ADD_Z on three consecutive enabled cycles. RES and RES_VALID are visible in the cycle after the ADD_Z cycle.
- Latency from the LOAD cycle to RES_VALID=1 is 3 cycles.
- EN=0 gaps between steps are legal and stretch the latency.
- X, Y and Z only need to be stable in the LOAD cycle.
- RES is stable while RES_VALID=1, except on an overrun.
- The earliest next LOAD is the cycle after ADD_Z, giving back-to-back throughput of 1 result per 3 cycles.
- There is no combinational path from any input to any output.

## Structure
- Package adder_pkg holds:
  - typedef enum step_t {STEP_NONE, STEP_LOAD, STEP_ADD_Y, STEP_ADD_Z, STEP_ILLEGAL};
  - typedef enum seq_t {SEQ_IDLE, SEQ_LOADED, SEQ_ADDED};
  - function decode_step(EN, S0, S1, S2) returning step_t, shared with the bench's reference model.
- Sub-module adder_result_buf holds RES, RES_VALID, the handshake and OVR. Inputs: commit, sum, RES_READY, CLR, clk, reset.
- The top level holds the decode, the order checker, ACC/YR/ZR and SEQ_ERR.

## Test plan
- WIDTH=8, X=10, Y=20, Z=30, sequence LOAD, ADD_Y, ADD_Z, RES_READY=1 → RES=60, RES_VALID=1 for one cycle, flags 0.
- X=Y=Z=255 with 2 EN=0 gaps between steps → RES=765, RES_VALID 5 cycles after LOAD; X changed after LOAD has no effect.
- Two back-to-back sequences (1+2+3, then 4+5+6) with RES_READY=0 → RES=15, RES_VALID=1, OVR=1; CLR → OVR=0, RES still 15.
- ADD_Y from IDLE, then EN=1 with S0=S2=1 → SEQ_ERR=1, ACC unchanged, FSM IDLE; a following legal sequence still gives the correct sum.
- reset asserted during ADDED, then LOAD, ADD_Y, ADD_Z of 7+8+9 → all outputs 0 after reset, then RES=24, SEQ_ERR=0.
- LOAD, LOAD, ADD_Y, ADD_Z (X=1 then X=2, Y=3, Z=4) → SEQ_ERR=1, RES=9.
